// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: rotating-priority winner search, per-requester
// credit for consecutive wins, and a registered one-hot grant held per transaction.
module wrr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            ack,
  input  logic            last,
  output logic [N-1:0]    gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n, cur, cur_n, gnt_id_n;
  logic [IDW-1:0] start, win, cur_inc;
  logic [WW-1:0]  credit, credit_n;
  logic [N-1:0]   gnt_n;
  logic           busy_n, found, done, abort;

  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] i);
    return (i == IDW'(N - 1)) ? '0 : i + IDW'(1);
  endfunction

  // Returns {hit, index} of the first set request at or after s, wrapping.
  function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] s);
    logic           hit;
    logic [IDW-1:0] idx;
    int             j;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      j   = int'(s) + k;
      j   = (j >= N) ? j - N : j;
      idx = (!hit && r[j]) ? IDW'(j) : idx;
      hit = hit | r[j];
    end
    return {hit, idx};
  endfunction

  // A zero weight behaves as weight 1, i.e. no extra consecutive wins.
  function automatic logic [WW-1:0] load_credit(input logic [N*WW-1:0] wv,
                                                input logic [IDW-1:0]  w);
    logic [WW-1:0] wt;
    wt = wv[int'(w)*WW +: WW];
    return (wt == '0) ? '0 : wt - WW'(1);
  endfunction

  // Next-state, credit and grant decode.
  always_comb begin
    cur_inc      = inc_mod(cur);
    start        = (state == BUSY) ? cur_inc : ptr;
    {found, win} = pick(req, start);
    abort        = ~req[cur];
    done         = ack & last;
    state_n      = state;
    ptr_n        = ptr;
    cur_n        = cur;
    credit_n     = credit;
    gnt_n        = gnt;
    gnt_id_n     = gnt_id;
    busy_n       = busy;
    case (state)
      IDLE: begin
        if (en && found) begin
          state_n    = BUSY;
          cur_n      = win;
          gnt_id_n   = win;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          busy_n     = 1'b1;
          credit_n   = load_credit(weight, win);
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        // An abort (owner dropped req) takes precedence over any ack that cycle.
        if (abort || done) begin
          if (!abort && en && credit != '0) begin
            credit_n = credit - WW'(1);
          end else if (en && found) begin
            ptr_n      = cur_inc;
            cur_n      = win;
            gnt_id_n   = win;
            gnt_n      = '0;
            gnt_n[win] = 1'b1;
            credit_n   = load_credit(weight, win);
          end else begin
            state_n = IDLE;
            ptr_n   = cur_inc;
            gnt_n   = '0;
            busy_n  = 1'b0;
          end
        end else begin
          state_n = BUSY;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      ptr    <= '0;
      cur    <= '0;
      credit <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cur    <= cur_n;
      credit <= credit_n;
      gnt    <= gnt_n;
      gnt_id <= gnt_id_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter for N requesters, with a registered one-hot grant.
- A grant is held for a whole transaction; it is released on the cycle the owner completes with ack and last both high.
- Each requester may win up to WEIGHT consecutive transactions before priority rotates to the next requester.
- Sits in front of shared datapath resources (bus, memory port, output FIFO) that multiple channels contend for.

Parameters:
- N, 4, number of requesters (2..16).
- WW, 4, width of each per-requester weight field.
- IDW, $clog2(N), width of gnt_id (derived, do not override).

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; when low, no new grant is issued and state is frozen (an active grant is still held and may complete).
- req  input  N  request vector; bit i high = requester i wants the resource.
- weight  input  N*WW  packed weights; requester i uses bits [i*WW +: WW]; value 0 is treated as 1.
- ack  input  1  resource accepted a beat from the current owner.
- last  input  1  the beat accepted with ack is the final beat of the transaction.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_id  output  IDW  binary index of the owner; valid only when busy=1.
- busy  output  1  high while any grant is active.

Behaviour:
- Reset: gnt=0, gnt_id=0, busy=0, state=IDLE, ptr=0, cur=0, credit=0.
- State machine has two states, IDLE and BUSY.
- Winner selection (combinational):
  - Rotating-priority search of req starting at index ptr, wrapping N-1 -> 0.
  - The first set bit wins.
- IDLE:
  - If en=1 and req!=0: the winner w is computed this cycle.
  - Next cycle: gnt=onehot(w), gnt_id=w, busy=1, state=BUSY.
  - credit loads max(weight[w],1)-1, with weight sampled at the grant cycle.
  - Request-to-grant latency is 1 clk.
- BUSY, transaction completes when ack & last:
  - If credit>0 and req[cur]=1 and en=1: re-grant cur; credit decrements by 1.
  - Otherwise: search again with ptr=cur+1 (mod N). The new winner is granted next cycle and credit reloads from its weight.
  - If there is no new winner, or en=0: go to IDLE with gnt=0, busy=0, ptr=cur+1 (mod N).
  - Back-to-back grants have no idle bubble; gnt changes directly from one one-hot value to the next.
- BUSY, ack without last: no change; the grant is held.
- BUSY, req[cur] falls without ack&last (abort):
  - Handled like a completion with credit forced to 0.
  - The grant moves to the next requester, or the block returns to IDLE, on the next cycle.
  - Any ack on that cycle is ignored for accounting.
- ack or last while IDLE: ignored.
- Weight changes take effect only at the next credit reload; they never alter an in-flight credit.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt!=0 iff busy=1.
  - gnt_id == index(gnt) whenever busy=1.
- Fairness: with all N requesting continuously and all weights=1, each requester is granted exactly once every N transactions.
- Reset asserted mid-transaction: all outputs drop to their reset values immediately (async); no completion is reported.

Test Plan:
- N=4, weights all 1, req=4'b1111 held, every grant completes with a single ack&last beat -> gnt sequence 0001,0010,0100,1000,0001 on consecutive transaction boundaries; no cycle with gnt=0.
- weight={1,1,1,3} (req0 weight 3), req=4'b0011 held -> gnt pattern 0001,0001,0001,0010,0001,0001,0001,0010.
- req=4'b0100 from IDLE at cycle t -> gnt=0100, gnt_id=2, busy=1 at t+1; 3 ack beats with last only on the 3rd -> gnt held until the 3rd beat, then 0 on the following cycle; next grant search starts from requester 3.
- Owner 1 granted; req[1] drops mid-transaction with req=4'b1001 -> next cycle gnt=1000 (search from 2 finds 3); no credit reuse for requester 1.
- en=0 while BUSY, then ack&last -> grant released, gnt=0 and busy=0 next cycle even though req!=0; raising en=1 -> grant issued 1 clk later.
- rstn pulsed low while gnt=0100 with ack beats pending -> gnt=0, busy=0 immediately; after release with req=4'b1111 -> first grant 0001 (ptr reset to 0).
